// File: rtl/mri_mesh_rd_xbar_if.sv
// Bundled client-request, mesh-request, mesh-response and client-response buses of the mesh read crossbar.
// The crossbar itself connects through the slave modport; the client/mesh side uses master.
interface mri_mesh_rd_xbar_if #(
    parameter int NUM_CLIENTS  = 3,
    parameter int NUM_ROWS     = 2,
    parameter int ADDR_W       = 20,
    parameter int ID_W         = 4,
    parameter int DATA_W       = 512,
    parameter int TAGS_PER_ROW = 16
);
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int TAG_W = (TAGS_PER_ROW > 1) ? $clog2(TAGS_PER_ROW) : 1;

    // Handshake: a transfer happens on a clock edge where valid && ready; a producer holding
    // valid keeps its payload stable until that edge. rsp_valid has no ready and is a one-cycle pulse.
    logic [NUM_CLIENTS-1:0]        req_valid;
    logic [NUM_CLIENTS-1:0]        req_ready;
    logic [NUM_CLIENTS*ROW_W-1:0]  req_row;
    logic [NUM_CLIENTS*ADDR_W-1:0] req_addr;
    logic [NUM_CLIENTS*ID_W-1:0]   req_id;
    logic [NUM_ROWS-1:0]           mesh_rd_valid;
    logic [NUM_ROWS-1:0]           mesh_rd_ready;
    logic [NUM_ROWS*ADDR_W-1:0]    mesh_rd_addr;
    logic [NUM_ROWS*TAG_W-1:0]     mesh_rd_tag;
    logic [NUM_ROWS-1:0]           mesh_rsp_valid;
    logic [NUM_ROWS-1:0]           mesh_rsp_ready;
    logic [NUM_ROWS*TAG_W-1:0]     mesh_rsp_tag;
    logic [NUM_ROWS*DATA_W-1:0]    mesh_rsp_data;
    logic [NUM_CLIENTS-1:0]        rsp_valid;
    logic [NUM_CLIENTS*ID_W-1:0]   rsp_id;
    logic [NUM_CLIENTS*DATA_W-1:0] rsp_data;
    logic                          err_unexp_tag;

    modport master (
        output req_valid, req_row, req_addr, req_id, mesh_rd_ready,
        output mesh_rsp_valid, mesh_rsp_tag, mesh_rsp_data,
        input  req_ready, mesh_rd_valid, mesh_rd_addr, mesh_rd_tag, mesh_rsp_ready,
        input  rsp_valid, rsp_id, rsp_data, err_unexp_tag
    );

    modport slave (
        input  req_valid, req_row, req_addr, req_id, mesh_rd_ready,
        input  mesh_rsp_valid, mesh_rsp_tag, mesh_rsp_data,
        output req_ready, mesh_rd_valid, mesh_rd_addr, mesh_rd_tag, mesh_rsp_ready,
        output rsp_valid, rsp_id, rsp_data, err_unexp_tag
    );
endinterface

// File: rtl/mri_mesh_rd_xbar.sv
// Mesh read crossbar: per-row round-robin request arbitration with tag pools, response routing back to clients.
// Optional MRI_TAG_CHECK_EN: drop responses whose tag is not outstanding and flag err_unexp_tag (sticky).
module mri_mesh_rd_xbar #(
    parameter int NUM_CLIENTS  = 3,
    parameter int NUM_ROWS     = 2,
    parameter int ADDR_W       = 20,
    parameter int ID_W         = 4,
    parameter int DATA_W       = 512,
    parameter int TAGS_PER_ROW = 16
) (
    input logic               clk,
    input logic               rst_n,
    mri_mesh_rd_xbar_if.slave bus
);
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int TAG_W = (TAGS_PER_ROW > 1) ? $clog2(TAGS_PER_ROW) : 1;
    localparam int CL_W  = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    logic [NUM_ROWS-1:0][TAGS_PER_ROW-1:0] busy_q, busy_d;
    logic [NUM_ROWS-1:0][CL_W-1:0]         ptr_q, ptr_d;
    logic [NUM_ROWS-1:0]                   rd_valid_q, rd_valid_d;
    logic [NUM_ROWS-1:0][ADDR_W-1:0]       rd_addr_q, rd_addr_d;
    logic [NUM_ROWS-1:0][TAG_W-1:0]        rd_tag_q, rd_tag_d;
    logic [NUM_CLIENTS-1:0]                rsp_valid_q, rsp_valid_d;
    logic [NUM_CLIENTS-1:0][ID_W-1:0]      rsp_id_q, rsp_id_d;
    logic [NUM_CLIENTS-1:0][DATA_W-1:0]    rsp_data_q, rsp_data_d;

    // Tag table holds routing info only; it is not reset, so a stale entry survives reset.
    logic [CL_W-1:0] tbl_cl_q [NUM_ROWS][TAGS_PER_ROW];
    logic [ID_W-1:0] tbl_id_q [NUM_ROWS][TAGS_PER_ROW];

    logic [NUM_CLIENTS-1:0]          req_ready;
    logic [NUM_ROWS-1:0]             free_any, gnt_any;
    logic [NUM_ROWS-1:0][TAG_W-1:0]  free_tag;
    logic [NUM_ROWS-1:0][CL_W-1:0]   gnt_cl;
    logic [NUM_ROWS-1:0][ADDR_W-1:0] gnt_addr;
    logic [NUM_ROWS-1:0][ID_W-1:0]   gnt_id;
    logic [NUM_ROWS-1:0][TAG_W-1:0]  rsp_tag;
    logic [NUM_ROWS-1:0][CL_W-1:0]   rsp_cl;
    logic [NUM_ROWS-1:0]             tag_hit, rsp_rdy;
    logic [NUM_CLIENTS-1:0]          claimed;
    int                              c;

    always_comb begin
        req_ready = '0;
        free_any  = '0;
        free_tag  = '0;
        gnt_any   = '0;
        gnt_cl    = '0;
        gnt_addr  = '0;
        gnt_id    = '0;
        c         = 0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int t = TAGS_PER_ROW - 1; t >= 0; t--) begin
                if (!busy_q[r][t]) begin
                    free_any[r] = 1'b1;
                    free_tag[r] = TAG_W'(t);
                end
            end
            if (free_any[r] && (!rd_valid_q[r] || bus.mesh_rd_ready[r])) begin
                for (int k = 0; k < NUM_CLIENTS; k++) begin
                    c = int'(ptr_q[r]) + k;
                    if (c >= NUM_CLIENTS) c = c - NUM_CLIENTS;
                    if (!gnt_any[r] && bus.req_valid[c] &&
                        bus.req_row[c*ROW_W +: ROW_W] == ROW_W'(r)) begin
                        gnt_any[r]   = 1'b1;
                        gnt_cl[r]    = CL_W'(c);
                        gnt_addr[r]  = bus.req_addr[c*ADDR_W +: ADDR_W];
                        gnt_id[r]    = bus.req_id[c*ID_W +: ID_W];
                        req_ready[c] = 1'b1;
                    end
                end
            end
        end
    end

    // Lower rows claim a client first; a higher row aimed at an already-claimed client stalls.
    always_comb begin
        rsp_tag     = '0;
        rsp_cl      = '0;
        tag_hit     = '0;
        rsp_rdy     = '0;
        claimed     = '0;
        rsp_valid_d = '0;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        for (int r = 0; r < NUM_ROWS; r++) begin
            rsp_tag[r] = bus.mesh_rsp_tag[r*TAG_W +: TAG_W];
            rsp_cl[r]  = tbl_cl_q[r][rsp_tag[r]];
`ifdef MRI_TAG_CHECK_EN
            tag_hit[r] = busy_q[r][rsp_tag[r]];
`else
            tag_hit[r] = 1'b1;
`endif
            if (!tag_hit[r]) begin
                rsp_rdy[r] = 1'b1;
            end else if (bus.mesh_rsp_valid[r] && claimed[rsp_cl[r]]) begin
                rsp_rdy[r] = 1'b0;
            end else begin
                rsp_rdy[r] = 1'b1;
                if (bus.mesh_rsp_valid[r]) begin
                    claimed[rsp_cl[r]]     = 1'b1;
                    rsp_valid_d[rsp_cl[r]] = 1'b1;
                    rsp_id_d[rsp_cl[r]]    = tbl_id_q[r][rsp_tag[r]];
                    rsp_data_d[rsp_cl[r]]  = bus.mesh_rsp_data[r*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        busy_d     = busy_q;
        ptr_d      = ptr_q;
        rd_valid_d = rd_valid_q;
        rd_addr_d  = rd_addr_q;
        rd_tag_d   = rd_tag_q;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (bus.mesh_rsp_valid[r] && rsp_rdy[r]) busy_d[r][rsp_tag[r]] = 1'b0;
            if (gnt_any[r]) begin
                busy_d[r][free_tag[r]] = 1'b1;
                rd_valid_d[r] = 1'b1;
                rd_addr_d[r]  = gnt_addr[r];
                rd_tag_d[r]   = free_tag[r];
                ptr_d[r]      = (int'(gnt_cl[r]) == NUM_CLIENTS - 1) ? '0 : CL_W'(gnt_cl[r] + 1'b1);
            end else if (bus.mesh_rd_ready[r]) begin
                rd_valid_d[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= '0;
            ptr_q       <= '0;
            rd_valid_q  <= '0;
            rd_addr_q   <= '0;
            rd_tag_q    <= '0;
            rsp_valid_q <= '0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            busy_q      <= busy_d;
            ptr_q       <= ptr_d;
            rd_valid_q  <= rd_valid_d;
            rd_addr_q   <= rd_addr_d;
            rd_tag_q    <= rd_tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (gnt_any[r]) begin
                tbl_cl_q[r][free_tag[r]] <= gnt_cl[r];
                tbl_id_q[r][free_tag[r]] <= gnt_id[r];
            end
        end
    end

`ifdef MRI_TAG_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (bus.mesh_rsp_valid[r] && !tag_hit[r]) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign bus.err_unexp_tag = err_q;
`else
    assign bus.err_unexp_tag = 1'b0;
`endif

    assign bus.req_ready      = req_ready;
    assign bus.mesh_rd_valid  = rd_valid_q;
    assign bus.mesh_rd_addr   = rd_addr_q;
    assign bus.mesh_rd_tag    = rd_tag_q;
    assign bus.mesh_rsp_ready = rsp_rdy;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_id         = rsp_id_q;
    assign bus.rsp_data       = rsp_data_q;
endmodule

// File: tb/tb_mri_mesh_rd_xbar.sv
// Directed bench for mri_mesh_rd_xbar: stimulus pushes expected mesh requests and client responses
// into queues; a negedge monitor pops and compares whenever the DUT presents a transfer.
`timescale 1ns/1ps
module tb_mri_mesh_rd_xbar;
    localparam int NC  = 3;
    localparam int NR  = 2;
    localparam int AW  = 20;
    localparam int IW  = 4;
    localparam int DW  = 512;
    localparam int TPR = 16;
    localparam int TW  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mri_mesh_rd_xbar_if #(.NUM_CLIENTS(NC), .NUM_ROWS(NR), .ADDR_W(AW), .ID_W(IW),
                          .DATA_W(DW), .TAGS_PER_ROW(TPR)) bus ();

    mri_mesh_rd_xbar #(.NUM_CLIENTS(NC), .NUM_ROWS(NR), .ADDR_W(AW), .ID_W(IW),
                       .DATA_W(DW), .TAGS_PER_ROW(TPR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [AW+TW-1:0] mexp_q[NR][$];
    logic [IW+DW-1:0] rexp_q[NC][$];
    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] mk_data(input logic [31:0] seed);
        return {16{seed}};
    endfunction

    // monitor / scoreboard
    logic [AW+TW-1:0] m_exp;
    logic [IW+DW-1:0] r_exp;
    always @(negedge clk) begin
        if (rst_n) begin
            for (int r = 0; r < NR; r++) begin
                if (bus.mesh_rd_valid[r] && bus.mesh_rd_ready[r]) begin
                    if (mexp_q[r].size() == 0) begin
                        check($sformatf("mesh_rd_unexpected_row%0d", r), 64'd1, 64'd0);
                    end else begin
                        m_exp = mexp_q[r].pop_front();
                        check($sformatf("mesh_rd_row%0d", r),
                              {bus.mesh_rd_addr[r*AW +: AW], bus.mesh_rd_tag[r*TW +: TW]}, m_exp);
                    end
                end
            end
            for (int c = 0; c < NC; c++) begin
                if (bus.rsp_valid[c]) begin
                    if (rexp_q[c].size() == 0) begin
                        check($sformatf("rsp_unexpected_c%0d", c), 64'd1, 64'd0);
                    end else begin
                        r_exp = rexp_q[c].pop_front();
                        check($sformatf("rsp_id_c%0d", c), bus.rsp_id[c*IW +: IW], r_exp[IW+DW-1:DW]);
                        chk_cnt++;
                        if (bus.rsp_data[c*DW +: DW] === r_exp[DW-1:0]) pass_cnt++;
                        else $display("FAIL rsp_data_c%0d: got %h expected %h", c,
                                      bus.rsp_data[c*DW +: DW], r_exp[DW-1:0]);
                    end
                end
            end
        end
    end

    // drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid      = '0;
        bus.mesh_rsp_valid = '0;
        bus.mesh_rd_ready  = '1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic issue_req(input int c, input int row, input logic [AW-1:0] addr,
                             input logic [IW-1:0] id, input logic [TW-1:0] exp_tag);
        int n = 0;
        bus.req_row[c]            = row[0];
        bus.req_addr[c*AW +: AW]  = addr;
        bus.req_id[c*IW +: IW]    = id;
        bus.req_valid[c]          = 1'b1;
        @(negedge clk);
        while (!bus.req_ready[c] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("req_ready_c%0d", c), bus.req_ready[c], 1);
        if (bus.req_ready[c]) mexp_q[row].push_back({addr, exp_tag});
        tick();
        bus.req_valid[c] = 1'b0;
    endtask

    task automatic send_rsp(input int row, input logic [TW-1:0] tag, input logic [DW-1:0] data);
        int n = 0;
        bus.mesh_rsp_tag[row*TW +: TW]  = tag;
        bus.mesh_rsp_data[row*DW +: DW] = data;
        bus.mesh_rsp_valid[row]         = 1'b1;
        @(negedge clk);
        while (!bus.mesh_rsp_ready[row] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("mesh_rsp_ready_row%0d", row), bus.mesh_rsp_ready[row], 1);
        tick();
        bus.mesh_rsp_valid[row] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid      = '0;
        bus.req_row        = '0;
        bus.req_addr       = '0;
        bus.req_id         = '0;
        bus.mesh_rd_ready  = '1;
        bus.mesh_rsp_valid = '0;
        bus.mesh_rsp_tag   = '0;
        bus.mesh_rsp_data  = '0;
        do_reset();

        // reset state
        @(negedge clk);
        check("rst_mesh_rd_valid", bus.mesh_rd_valid, 0);
        check("rst_mesh_rd_addr", bus.mesh_rd_addr, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_err", bus.err_unexp_tag, 0);
        tick();

        // single read: client 1, row 0
        issue_req(1, 0, 20'h00123, 4'd5, 4'd0);
        @(negedge clk);
        check("single_rd_latency", bus.mesh_rd_valid, 2'b01);
        tick();
        rexp_q[1].push_back({4'd5, mk_data(32'hD00D_0001)});
        send_rsp(0, 4'd0, mk_data(32'hD00D_0001));
        @(negedge clk);
        check("single_rsp_latency", bus.rsp_valid, 3'b010);
        tick();

        // round-robin fairness on row 1
        do_reset();
        for (int c = 0; c < NC; c++) begin
            bus.req_row[c]           = 1'b1;
            bus.req_addr[c*AW +: AW] = 20'h00100 + AW'(c);
            bus.req_id[c*IW +: IW]   = IW'(c);
        end
        for (int i = 0; i < 6; i++) mexp_q[1].push_back({20'h00100 + AW'(i % 3), TW'(i)});
        bus.req_valid = 3'b111;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("rr_grant%0d", i), bus.req_ready, 64'(3'b001 << (i % 3)));
            tick();
        end
        bus.req_valid = '0;
        repeat (2) tick();

        // tag exhaustion on row 0, then reuse of freed tag 7
        do_reset();
        bus.req_row[0]   = 1'b0;
        bus.req_valid[0] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.req_addr[0 +: AW] = 20'h00A00 + AW'(i);
            bus.req_id[0 +: IW]   = IW'(i);
            @(negedge clk);
            check($sformatf("exh_grant%0d", i), bus.req_ready[0], 1);
            mexp_q[0].push_back({20'h00A00 + AW'(i), TW'(i)});
            tick();
        end
        bus.req_addr[0 +: AW] = 20'h00A10;
        bus.req_id[0 +: IW]   = 4'hE;
        @(negedge clk);
        check("exh_full0", bus.req_ready[0], 0);
        tick();
        @(negedge clk);
        check("exh_full1", bus.req_ready[0], 0);
        tick();
        rexp_q[0].push_back({4'd7, mk_data(32'h7777_0007)});
        bus.mesh_rsp_tag[0 +: TW]  = 4'd7;
        bus.mesh_rsp_data[0 +: DW] = mk_data(32'h7777_0007);
        bus.mesh_rsp_valid[0]      = 1'b1;
        @(negedge clk);
        check("exh_free_same_cycle", bus.req_ready[0], 0);
        check("exh_rsp_ready", bus.mesh_rsp_ready[0], 1);
        tick();
        bus.mesh_rsp_valid[0] = 1'b0;
        @(negedge clk);
        check("exh_realloc", bus.req_ready[0], 1);
        mexp_q[0].push_back({20'h00A10, 4'd7});
        tick();
        bus.req_valid[0] = 1'b0;
        repeat (2) tick();

        // response collision on client 2
        do_reset();
        issue_req(2, 0, 20'h00111, 4'd3, 4'd0);
        issue_req(2, 1, 20'h00222, 4'd9, 4'd0);
        tick();
        rexp_q[2].push_back({4'd3, mk_data(32'hAAAA_0000)});
        rexp_q[2].push_back({4'd9, mk_data(32'hBBBB_1111)});
        bus.mesh_rsp_tag           = '0;
        bus.mesh_rsp_data[0 +: DW] = mk_data(32'hAAAA_0000);
        bus.mesh_rsp_data[DW +: DW] = mk_data(32'hBBBB_1111);
        bus.mesh_rsp_valid         = 2'b11;
        @(negedge clk);
        check("coll_ready", bus.mesh_rsp_ready, 2'b01);
        tick();
        bus.mesh_rsp_valid[0] = 1'b0;
        @(negedge clk);
        check("coll_ready_row1", bus.mesh_rsp_ready[1], 1);
        check("coll_first", bus.rsp_valid, 3'b100);
        tick();
        bus.mesh_rsp_valid[1] = 1'b0;
        @(negedge clk);
        check("coll_second", bus.rsp_valid, 3'b100);
        tick();

        // mesh request backpressure on row 0
        do_reset();
        bus.mesh_rd_ready[0] = 1'b0;
        issue_req(0, 0, 20'h0ABCD, 4'd1, 4'd0);
        bus.req_row[1]         = 1'b0;
        bus.req_addr[AW +: AW] = 20'h0BEEF;
        bus.req_id[IW +: IW]   = 4'd2;
        bus.req_valid[1]       = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", bus.mesh_rd_valid[0], 1);
            check("bp_addr", bus.mesh_rd_addr[0 +: AW], 20'h0ABCD);
            check("bp_tag", bus.mesh_rd_tag[0 +: TW], 4'd0);
            check("bp_no_grant", bus.req_ready[1], 0);
            tick();
        end
        bus.mesh_rd_ready[0] = 1'b1;
        @(negedge clk);
        check("bp_resume", bus.req_ready[1], 1);
        mexp_q[0].push_back({20'h0BEEF, 4'd1});
        tick();
        bus.req_valid[1] = 1'b0;
        repeat (2) tick();

        // reset with three tags outstanding on row 0
        do_reset();
        issue_req(0, 0, 20'h00300, 4'd1, 4'd0);
        issue_req(0, 0, 20'h00301, 4'd2, 4'd1);
        issue_req(0, 0, 20'h00302, 4'd3, 4'd2);
        repeat (2) tick();
        do_reset();
`ifdef MRI_TAG_CHECK_EN
        send_rsp(0, 4'd2, mk_data(32'hDEAD_0002));
        @(negedge clk);
        check("unexp_no_rsp", bus.rsp_valid, 0);
        check("unexp_err", bus.err_unexp_tag, 1);
        repeat (3) tick();
        @(negedge clk);
        check("unexp_err_sticky", bus.err_unexp_tag, 1);
`else
        rexp_q[0].push_back({4'd3, mk_data(32'hDEAD_0002)});
        send_rsp(0, 4'd2, mk_data(32'hDEAD_0002));
        @(negedge clk);
        check("stale_rsp_fwd", bus.rsp_valid, 3'b001);
        check("err_tied_low", bus.err_unexp_tag, 0);
`endif
        repeat (3) tick();

        for (int r = 0; r < NR; r++) check($sformatf("mesh_q_drained_row%0d", r), mexp_q[r].size(), 0);
        for (int c = 0; c < NC; c++) check($sformatf("rsp_q_drained_c%0d", c), rexp_q[c].size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
